// File: rtl/servo_pkg.sv
// Shared types and limits for the servo pulse-width path.
// Widths are in 10 us units as consumed by the PWM generator.
package servo_pkg;

  typedef logic [10:0] width_t;

  localparam int PWM_FULL       = 2000;
  localparam int SERVO_W_MIN    = 100;
  localparam int SERVO_W_MAX    = 200;
  localparam int SERVO_W_CENTER = 150;

  typedef enum logic {
    HOLD,
    RAMP
  } state_t;

  // One bounded move of p toward t; 12-bit math avoids wrap.
  function automatic width_t slew(
    width_t      p,
    width_t      t,
    logic [11:0] step
  );
    logic [11:0] p12;
    logic [11:0] t12;
    logic [11:0] r;
    p12 = {1'b0, p};
    t12 = {1'b0, t};
    if (t12 > p12)
      r = ((t12 - p12) <= step) ? t12 : p12 + step;
    else
      r = ((p12 - t12) <= step) ? t12 : p12 - step;
    return r[10:0];
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Free-running frame counter with a registered one-cycle tick
// on each wrap; reusable by any servo-rate logic.
module frame_timer #(
  parameter int FRAME_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int CW =
    (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      cnt  <= (cnt == LAST) ? '0 : cnt + CW'(1);
      tick <= (cnt == LAST);
    end
  end

endmodule

// File: rtl/servo_slew.sv
// Clamps servo width commands and slews the PWM width toward
// the target by at most STEP per frame.
import servo_pkg::*;

module servo_slew #(
  parameter int FRAME_CYCLES = 1000000,
  parameter int W_MIN        = SERVO_W_MIN,
  parameter int W_MAX        = SERVO_W_MAX,
  parameter int W_CENTER     = SERVO_W_CENTER,
  parameter int STEP         = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        cmd_valid,
  input  logic [10:0] cmd_width,
  output logic        cmd_ready,
  output logic [10:0] width_out,
  output logic        at_target,
  output logic        frame_tick,
  output logic        cmd_clamped
);

  localparam int     W_HI  = (W_MAX > PWM_FULL) ? PWM_FULL : W_MAX;
  localparam width_t WLO   = width_t'(W_MIN);
  localparam width_t WHI   = width_t'(W_HI);
  localparam width_t WCTR  = width_t'(W_CENTER);
  localparam logic [11:0] STEP12 = 12'(STEP);

  state_t state;
  state_t state_n;
  width_t pos;
  width_t pos_n;
  width_t target;
  width_t target_n;
  width_t clamped;
  logic   accept;
  logic   clip;
  logic   tick;

  frame_timer #(
    .FRAME_CYCLES(FRAME_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  assign frame_tick = tick;

  // Slew sees the pre-accept target; the new one lands next cycle.
  always_comb begin
    accept   = cmd_valid & cmd_ready;
    clip     = (cmd_width < WLO) | (cmd_width > WHI);
    clamped  = cmd_width;
    if (cmd_width < WLO)
      clamped = WLO;
    else if (cmd_width > WHI)
      clamped = WHI;
    pos_n    = pos;
    target_n = accept ? clamped : target;
    unique case (1'b1)
      (state == HOLD): pos_n = pos;
      (state == RAMP): if (tick) pos_n = slew(pos, target, STEP12);
    endcase
    state_n  = (pos_n == target_n) ? HOLD : RAMP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= HOLD;
      pos         <= WCTR;
      target      <= WCTR;
      cmd_ready   <= 1'b0;
      at_target   <= 1'b1;
      cmd_clamped <= 1'b0;
      width_out   <= '0;
    end else begin
      state       <= state_n;
      pos         <= pos_n;
      target      <= target_n;
      cmd_ready   <= 1'b1;
      at_target   <= (state_n == HOLD);
      cmd_clamped <= accept & clip;
      width_out   <= en ? pos : '0;
    end
  end

endmodule

// File: tb/tb_servo_slew.sv
// Bench for servo_slew: command table with a width scoreboard,
// plus hand sequences for tick alignment, enable and reset.
module tb_servo_slew;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [10:0] cmd_width = '0;
  logic        cmd_ready;
  logic [10:0] width_out;
  logic        at_target;
  logic        frame_tick;
  logic        cmd_clamped;

  servo_slew #(
    .FRAME_CYCLES(8),
    .STEP(4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .cmd_valid  (cmd_valid),
    .cmd_width  (cmd_width),
    .cmd_ready  (cmd_ready),
    .width_out  (width_out),
    .at_target  (at_target),
    .frame_tick (frame_tick),
    .cmd_clamped(cmd_clamped)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cmd;
    int tgt;
    int clip;
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  int          q[$];
  int          mpos = 150;
  logic        mon_on = 1'b0;
  logic [10:0] last_w = '0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: every visible width change must be the next step.
  always @(posedge clk) begin
    #2;
    if (mon_on && width_out != last_w) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_width: got %0d expected none",
                 width_out);
      end else begin
        chk("ramp_step", width_out, q.pop_front());
      end
      checks++;
      if (width_out < 100 || width_out > 200) begin
        errors++;
        $display("FAIL range: got %0d expected 100..200",
                 width_out);
      end
    end
    last_w = width_out;
  end

  task automatic push_ramp(int tgt);
    while (mpos != tgt) begin
      if (tgt > mpos)
        mpos = (tgt - mpos <= 4) ? tgt : mpos + 4;
      else
        mpos = (mpos - tgt <= 4) ? tgt : mpos - 4;
      q.push_back(mpos);
    end
  endtask

  task automatic send(int w);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_width = 11'(w);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic drain(string name);
    int c;
    c = 0;
    while (c < 400 && !(q.size() == 0 && at_target === 1'b1)) begin
      @(negedge clk);
      c++;
    end
    chk(name, (q.size() == 0 && at_target === 1'b1), 1);
  endtask

  task automatic wait_tick(string name);
    int c;
    c = 0;
    while (c < 20 && frame_tick !== 1'b1) begin
      @(negedge clk);
      c++;
    end
    chk(name, frame_tick, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t tv[4];
    int   n;
    int   ticks;
    int   c;
    logic ok;

    tv[0] = '{cmd: 170,  tgt: 170, clip: 0};
    tv[1] = '{cmd: 2047, tgt: 200, clip: 1};
    tv[2] = '{cmd: 5,    tgt: 100, clip: 1};
    tv[3] = '{cmd: 150,  tgt: 150, clip: 0};

    // Reset state and enable latency
    repeat (3) @(negedge clk);
    chk("rst_width", width_out, 0);
    chk("rst_at_target", at_target, 1);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_tick", frame_tick, 0);
    chk("rst_clamped", cmd_clamped, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1);
    chk("width_disabled", width_out, 0);
    en = 1'b1;
    @(negedge clk);
    chk("width_on_enable", width_out, 150);
    chk("at_target_idle", at_target, 1);

    // Tick period and pulse width
    wait_tick("tick_seen");
    @(negedge clk);
    chk("tick_one_cycle", frame_tick, 0);
    n = 1;
    while (n < 20 && frame_tick !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    chk("tick_period", n, 8);

    // Command table through the scoreboard
    mon_on = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push_ramp(tv[i].tgt);
      send(tv[i].cmd);
      chk($sformatf("clamped_%0d", i), cmd_clamped, tv[i].clip);
      chk($sformatf("ramping_%0d", i), at_target, 0);
      @(negedge clk);
      chk($sformatf("clamp_pulse_%0d", i), cmd_clamped, 0);
      drain($sformatf("settle_%0d", i));
      chk($sformatf("final_%0d", i), width_out, tv[i].tgt);
    end

    // Accept coinciding with a tick: that tick uses old target
    wait_tick("align_tick");
    push_ramp(152);
    cmd_valid = 1'b1;
    cmd_width = 11'd152;
    @(negedge clk);
    cmd_valid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 7; i++) begin
      if (width_out != 150) ok = 1'b0;
      @(negedge clk);
    end
    chk("same_tick_hold", ok, 1);
    drain("settle_152");
    chk("no_overshoot", width_out, 152);

    // Disable mid-ramp for three frames
    push_ramp(162);
    send(162);
    drain("settle_162");
    mon_on = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_width = 11'd200;
    @(negedge clk);
    cmd_valid = 1'b0;
    en = 1'b0;
    ticks = 0;
    c = 0;
    ok = 1'b1;
    while (ticks < 3 && c < 40) begin
      if (frame_tick) ticks++;
      if (ticks < 3) begin
        @(negedge clk);
        c++;
        if (width_out != 0) ok = 1'b0;
      end
    end
    chk("disabled_ticks", ticks, 3);
    chk("disabled_zero", ok, 1);
    @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("reenable_width", width_out, 174);
    mpos = 174;
    push_ramp(200);
    mon_on = 1'b1;
    drain("settle_200");
    chk("final_200", width_out, 200);

    // Reset asserted between edges mid-ramp
    push_ramp(100);
    send(100);
    wait_tick("mid_tick");
    @(negedge clk);
    wait_tick("mid_tick2");
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_width", width_out, 0);
    chk("async_at_target", at_target, 1);
    chk("async_ready", cmd_ready, 0);
    mon_on = 1'b0;
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1);
    chk("post_rst_width", width_out, 150);
    repeat (20) @(negedge clk);
    chk("abandoned_width", width_out, 150);
    chk("abandoned_at_target", at_target, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
